// File: rtl/multicycle_pkg.sv
// Shared types and constants for the multicycle controller: FSM states,
// instruction classes, opcode match values/masks and ALU operation codes.
package multicycle_pkg;

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_MEMORY    = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_HALT      = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    CLS_NOP   = 3'd0,
    CLS_RTYPE = 3'd1,
    CLS_LDUR  = 3'd2,
    CLS_STUR  = 3'd3,
    CLS_CBZ   = 3'd4,
    CLS_CBNZ  = 3'd5,
    CLS_B     = 3'd6
  } iclass_e;

  localparam logic [10:0] OP_ADD  = 11'h458;
  localparam logic [10:0] OP_SUB  = 11'h658;
  localparam logic [10:0] OP_AND  = 11'h450;
  localparam logic [10:0] OP_ORR  = 11'h550;
  localparam logic [10:0] OP_LDUR = 11'h7C2;
  localparam logic [10:0] OP_STUR = 11'h7C0;
  localparam logic [10:0] OP_CBZ  = 11'h5A0;
  localparam logic [10:0] OP_CBNZ = 11'h5A8;
  localparam logic [10:0] MASK_CB = 11'h7F8;
  localparam logic [10:0] OP_B    = 11'h0A0;
  localparam logic [10:0] MASK_B  = 11'h7E0;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_PASSB = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  function automatic logic op_match(input logic [10:0] op,
                                    input logic [10:0] val,
                                    input logic [10:0] mask);
    return (op & mask) == val;
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath signal bundle; master is the controller side,
// slave is the datapath/memory side.
interface multicycle_control_if #(
  parameter int unsigned CNT_W = 16
);
  logic [10:0]      opcode;
  logic             mem_ready;
  logic             zero;
  logic             reg2_loc;
  logic             uncondbranch;
  logic             branch;
  logic             mem_read;
  logic             mem_to_reg;
  logic             mem_write;
  logic             alu_src;
  logic             reg_write;
  logic [1:0]       alu_op;
  logic             pc_write;
  logic             ir_write;
  logic             illegal;
  logic             fault;
  logic [2:0]       state;
  logic [CNT_W-1:0] retired;

  modport master (
    input  opcode, mem_ready, zero,
    output reg2_loc, uncondbranch, branch, mem_read, mem_to_reg, mem_write,
           alu_src, reg_write, alu_op, pc_write, ir_write, illegal, fault,
           state, retired
  );

  modport slave (
    output opcode, mem_ready, zero,
    input  reg2_loc, uncondbranch, branch, mem_read, mem_to_reg, mem_write,
           alu_src, reg_write, alu_op, pc_write, ir_write, illegal, fault,
           state, retired
  );
endinterface

// File: rtl/multicycle_control_opcode_decoder.sv
// Combinational opcode[31:21] -> instruction class mapping with valid bit.
// Define CBNZ_EN to decode 5A8-5AF as CBNZ; otherwise those are illegal.
module opcode_decoder
  import multicycle_pkg::*;
(
  input  logic [10:0] opcode_i,
  output iclass_e     cls_o,
  output logic        valid_o
);

  always_comb begin
    cls_o = CLS_NOP;
    if (opcode_i == OP_ADD || opcode_i == OP_SUB ||
        opcode_i == OP_AND || opcode_i == OP_ORR) begin
      cls_o = CLS_RTYPE;
    end else if (opcode_i == OP_LDUR) begin
      cls_o = CLS_LDUR;
    end else if (opcode_i == OP_STUR) begin
      cls_o = CLS_STUR;
    end else if (op_match(opcode_i, OP_CBZ, MASK_CB)) begin
      cls_o = CLS_CBZ;
`ifdef CBNZ_EN
    end else if (op_match(opcode_i, OP_CBNZ, MASK_CB)) begin
      cls_o = CLS_CBNZ;
`endif
    end else if (op_match(opcode_i, OP_B, MASK_B)) begin
      cls_o = CLS_B;
    end
  end

  assign valid_o = (cls_o != CLS_NOP);

endmodule

// File: rtl/multicycle_control.sv
// Multicycle LEGv8-style controller: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK FSM
// with memory-timeout HALT and retired counter. CBNZ_EN enables CBNZ decode.
module multicycle_control
  import multicycle_pkg::*;
#(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input logic                 clk,
  input logic                 rst,
  multicycle_control_if.master bus
);

  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 2);

  state_e            state_q;
  iclass_e           cls_q;
  logic              fault_q;
  logic [CNT_W-1:0]  retired_q;
  logic [WAIT_W-1:0] wait_q;

  iclass_e dec_cls;
  logic    dec_valid;

  opcode_decoder u_dec (
    .opcode_i (bus.opcode),
    .cls_o    (dec_cls),
    .valid_o  (dec_valid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_FETCH;
      cls_q     <= CLS_NOP;
      fault_q   <= 1'b0;
      retired_q <= '0;
      wait_q    <= '0;
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (bus.mem_ready) begin
            wait_q  <= '0;
            state_q <= ST_DECODE;
          end else if (wait_q == WAIT_W'(MEM_TIMEOUT)) begin
            fault_q <= 1'b1;
            state_q <= ST_HALT;
          end else begin
            wait_q <= wait_q + WAIT_W'(1);
          end
        end
        ST_DECODE: begin
          if (dec_valid) begin
            cls_q   <= dec_cls;
            state_q <= ST_EXECUTE;
          end else begin
            cls_q   <= CLS_NOP;
            state_q <= ST_FETCH;
          end
        end
        ST_EXECUTE: begin
          case (cls_q)
            CLS_RTYPE:           state_q <= ST_WRITEBACK;
            CLS_LDUR, CLS_STUR:  state_q <= ST_MEMORY;
            CLS_CBZ, CLS_CBNZ, CLS_B: begin
              retired_q <= retired_q + CNT_W'(1);
              state_q   <= ST_FETCH;
            end
            default:             state_q <= ST_FETCH;
          endcase
        end
        ST_MEMORY: begin
          if (bus.mem_ready) begin
            wait_q <= '0;
            if (cls_q == CLS_LDUR) begin
              state_q <= ST_WRITEBACK;
            end else begin
              retired_q <= retired_q + CNT_W'(1);
              state_q   <= ST_FETCH;
            end
          end else if (wait_q == WAIT_W'(MEM_TIMEOUT)) begin
            fault_q <= 1'b1;
            state_q <= ST_HALT;
          end else begin
            wait_q <= wait_q + WAIT_W'(1);
          end
        end
        ST_WRITEBACK: begin
          retired_q <= retired_q + CNT_W'(1);
          state_q   <= ST_FETCH;
        end
        ST_HALT: state_q <= ST_HALT;
        default: state_q <= ST_FETCH;
      endcase
    end
  end

  // Controls are a pure function of state, latched class and the live
  // handshake/flag inputs; ir_write is masked so reset shows only mem_read.
  always_comb begin
    bus.reg2_loc     = 1'b0;
    bus.uncondbranch = 1'b0;
    bus.branch       = 1'b0;
    bus.mem_read     = 1'b0;
    bus.mem_to_reg   = 1'b0;
    bus.mem_write    = 1'b0;
    bus.alu_src      = 1'b0;
    bus.reg_write    = 1'b0;
    bus.alu_op       = ALU_ADD;
    bus.pc_write     = 1'b0;
    bus.ir_write     = 1'b0;
    bus.illegal      = 1'b0;
    case (state_q)
      ST_FETCH: begin
        bus.mem_read = 1'b1;
        bus.ir_write = bus.mem_ready & ~rst;
      end
      ST_DECODE: begin
        bus.reg2_loc = (dec_cls == CLS_STUR) || (dec_cls == CLS_CBZ) ||
                       (dec_cls == CLS_CBNZ);
        bus.illegal  = ~dec_valid;
      end
      ST_EXECUTE: begin
        case (cls_q)
          CLS_RTYPE: bus.alu_op = ALU_FUNCT;
          CLS_LDUR, CLS_STUR: begin
            bus.alu_op  = ALU_ADD;
            bus.alu_src = 1'b1;
          end
          CLS_CBZ: begin
            bus.alu_op   = ALU_PASSB;
            bus.branch   = 1'b1;
            bus.pc_write = bus.zero;
          end
          CLS_CBNZ: begin
            bus.alu_op   = ALU_PASSB;
            bus.branch   = 1'b1;
            bus.pc_write = ~bus.zero;
          end
          CLS_B: begin
            bus.uncondbranch = 1'b1;
            bus.pc_write     = 1'b1;
          end
          default: ;
        endcase
      end
      ST_MEMORY: begin
        if (cls_q == CLS_LDUR) begin
          bus.mem_read = 1'b1;
        end else if (cls_q == CLS_STUR) begin
          bus.mem_write = 1'b1;
          bus.pc_write  = bus.mem_ready;
        end
      end
      ST_WRITEBACK: begin
        bus.reg_write  = 1'b1;
        bus.pc_write   = 1'b1;
        bus.mem_to_reg = (cls_q == CLS_LDUR);
      end
      default: ;
    endcase
  end

  assign bus.fault   = fault_q;
  assign bus.state   = state_q;
  assign bus.retired = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control; CBNZ_EN selects the
// expected behaviour of opcode 5A9.
module tb_multicycle_control;

  localparam int unsigned TB_CNT_W = 4;

  // ctl = {reg2_loc, uncondbranch, branch, mem_read, mem_to_reg, mem_write,
  //        alu_src, reg_write, alu_op[1:0], pc_write, ir_write, illegal}
  localparam logic [12:0] C_0   = 13'b0_0_0_0_0_0_0_0_00_0_0_0;
  localparam logic [12:0] C_F1  = 13'b0_0_0_1_0_0_0_0_00_0_1_0;
  localparam logic [12:0] C_F0  = 13'b0_0_0_1_0_0_0_0_00_0_0_0;
  localparam logic [12:0] C_D2  = 13'b1_0_0_0_0_0_0_0_00_0_0_0;
  localparam logic [12:0] C_ILL = 13'b0_0_0_0_0_0_0_0_00_0_0_1;
  localparam logic [12:0] C_ER  = 13'b0_0_0_0_0_0_0_0_10_0_0_0;
  localparam logic [12:0] C_EM  = 13'b0_0_0_0_0_0_1_0_00_0_0_0;
  localparam logic [12:0] C_WB  = 13'b0_0_0_0_0_0_0_1_00_1_0_0;
  localparam logic [12:0] C_WBL = 13'b0_0_0_0_1_0_0_1_00_1_0_0;
  localparam logic [12:0] C_ML  = 13'b0_0_0_1_0_0_0_0_00_0_0_0;
  localparam logic [12:0] C_MS0 = 13'b0_0_0_0_0_1_0_0_00_0_0_0;
  localparam logic [12:0] C_MS1 = 13'b0_0_0_0_0_1_0_0_00_1_0_0;
  localparam logic [12:0] C_CBT = 13'b0_0_1_0_0_0_0_0_01_1_0_0;
  localparam logic [12:0] C_CBF = 13'b0_0_1_0_0_0_0_0_01_0_0_0;
  localparam logic [12:0] C_B   = 13'b0_1_0_0_0_0_0_0_00_1_0_0;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   exp_retired;
  logic [12:0] ctl;

  multicycle_control_if #(.CNT_W(TB_CNT_W)) bus ();

  multicycle_control #(.CNT_W(TB_CNT_W), .MEM_TIMEOUT(15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  assign ctl = {bus.reg2_loc, bus.uncondbranch, bus.branch, bus.mem_read,
                bus.mem_to_reg, bus.mem_write, bus.alu_src, bus.reg_write,
                bus.alu_op, bus.pc_write, bus.ir_write, bus.illegal};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    bus.opcode = 11'h458; bus.mem_ready = 1'b1; bus.zero = 1'b1;
    #2;
    checks++; if (bus.state !== 3'd0) begin errors++;
      $display("FAIL reset_state: got %0d expected 0", bus.state); end
    checks++; if (ctl !== C_F0) begin errors++;
      $display("FAIL reset_ctl: got %b expected %b", ctl, C_F0); end
    checks++; if (bus.fault !== 1'b0) begin errors++;
      $display("FAIL reset_fault: got %b expected 0", bus.fault); end
    checks++; if (bus.retired !== 4'd0) begin errors++;
      $display("FAIL reset_retired: got %0d expected 0", bus.retired); end
    @(negedge clk); rst = 1'b0;
    exp_retired = 0;
  endtask

  task automatic test_add();
    logic [2:0]  es [4] = '{3'd0, 3'd1, 3'd2, 3'd4};
    logic [12:0] ec [4] = '{C_F1, C_0, C_ER, C_WB};
    bus.opcode = 11'h458; bus.mem_ready = 1'b1; bus.zero = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (bus.state !== es[i]) begin errors++;
        $display("FAIL add_state[%0d]: got %0d expected %0d", i, bus.state, es[i]); end
      checks++; if (ctl !== ec[i]) begin errors++;
        $display("FAIL add_ctl[%0d]: got %b expected %b", i, ctl, ec[i]); end
      @(posedge clk); #1;
    end
    exp_retired++;
    checks++; if (bus.state !== 3'd0) begin errors++;
      $display("FAIL add_end_state: got %0d expected 0", bus.state); end
    checks++; if (bus.retired !== TB_CNT_W'(exp_retired)) begin errors++;
      $display("FAIL add_retired: got %0d expected %0d", bus.retired, exp_retired); end
  endtask

  task automatic test_ldur_wait();
    logic [2:0]  es [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd4};
    logic [12:0] ec [8] = '{C_F1, C_0, C_EM, C_ML, C_ML, C_ML, C_ML, C_WBL};
    logic        mr [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    bus.opcode = 11'h7C2; bus.zero = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus.mem_ready = mr[i];
      #1;
      checks++; if (bus.state !== es[i]) begin errors++;
        $display("FAIL ldur_state[%0d]: got %0d expected %0d", i, bus.state, es[i]); end
      checks++; if (ctl !== ec[i]) begin errors++;
        $display("FAIL ldur_ctl[%0d]: got %b expected %b", i, ctl, ec[i]); end
      @(posedge clk); #1;
    end
    exp_retired++;
    checks++; if (bus.state !== 3'd0) begin errors++;
      $display("FAIL ldur_end_state: got %0d expected 0", bus.state); end
    checks++; if (bus.retired !== TB_CNT_W'(exp_retired)) begin errors++;
      $display("FAIL ldur_retired: got %0d expected %0d", bus.retired, exp_retired); end
  endtask

  task automatic test_stur_wait();
    logic [2:0]  es [6] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd3};
    logic [12:0] ec [6] = '{C_F0, C_F1, C_D2, C_EM, C_MS0, C_MS1};
    logic        mr [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    bus.opcode = 11'h7C0; bus.zero = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.mem_ready = mr[i];
      #1;
      checks++; if (bus.state !== es[i]) begin errors++;
        $display("FAIL stur_state[%0d]: got %0d expected %0d", i, bus.state, es[i]); end
      checks++; if (ctl !== ec[i]) begin errors++;
        $display("FAIL stur_ctl[%0d]: got %b expected %b", i, ctl, ec[i]); end
      @(posedge clk); #1;
    end
    exp_retired++;
    checks++; if (bus.state !== 3'd0) begin errors++;
      $display("FAIL stur_end_state: got %0d expected 0", bus.state); end
    checks++; if (bus.retired !== TB_CNT_W'(exp_retired)) begin errors++;
      $display("FAIL stur_retired: got %0d expected %0d", bus.retired, exp_retired); end
  endtask

  task automatic test_cbz();
    logic [2:0]  es [3] = '{3'd0, 3'd1, 3'd2};
    logic [12:0] ec [3];
    for (int z = 1; z >= 0; z--) begin
      ec = '{C_F1, C_D2, (z != 0) ? C_CBT : C_CBF};
      bus.opcode = 11'h5A3; bus.mem_ready = 1'b1; bus.zero = (z != 0);
      for (int i = 0; i < 3; i++) begin
        #1;
        checks++; if (bus.state !== es[i]) begin errors++;
          $display("FAIL cbz%0d_state[%0d]: got %0d expected %0d", z, i, bus.state, es[i]); end
        checks++; if (ctl !== ec[i]) begin errors++;
          $display("FAIL cbz%0d_ctl[%0d]: got %b expected %b", z, i, ctl, ec[i]); end
        @(posedge clk); #1;
      end
      exp_retired++;
      checks++; if (bus.retired !== TB_CNT_W'(exp_retired)) begin errors++;
        $display("FAIL cbz%0d_retired: got %0d expected %0d", z, bus.retired, exp_retired); end
    end
  endtask

  task automatic test_illegal(input logic [10:0] op);
    logic [2:0]  es [2] = '{3'd0, 3'd1};
    logic [12:0] ec [2] = '{C_F1, C_ILL};
    bus.opcode = op; bus.mem_ready = 1'b1; bus.zero = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (bus.state !== es[i]) begin errors++;
        $display("FAIL ill_%h_state[%0d]: got %0d expected %0d", op, i, bus.state, es[i]); end
      checks++; if (ctl !== ec[i]) begin errors++;
        $display("FAIL ill_%h_ctl[%0d]: got %b expected %b", op, i, ctl, ec[i]); end
      @(posedge clk); #1;
    end
    checks++; if (bus.state !== 3'd0) begin errors++;
      $display("FAIL ill_%h_end_state: got %0d expected 0", op, bus.state); end
    checks++; if (ctl !== C_F1) begin errors++;
      $display("FAIL ill_%h_pulse_end: got %b expected %b", op, ctl, C_F1); end
    checks++; if (bus.retired !== TB_CNT_W'(exp_retired)) begin errors++;
      $display("FAIL ill_%h_retired: got %0d expected %0d", op, bus.retired, exp_retired); end
  endtask

  task automatic test_cbnz();
`ifdef CBNZ_EN
    logic [2:0]  es [3] = '{3'd0, 3'd1, 3'd2};
    logic [12:0] ec [3] = '{C_F1, C_D2, C_CBT};
    bus.opcode = 11'h5A9; bus.mem_ready = 1'b1; bus.zero = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (bus.state !== es[i]) begin errors++;
        $display("FAIL cbnz_state[%0d]: got %0d expected %0d", i, bus.state, es[i]); end
      checks++; if (ctl !== ec[i]) begin errors++;
        $display("FAIL cbnz_ctl[%0d]: got %b expected %b", i, ctl, ec[i]); end
      @(posedge clk); #1;
    end
    exp_retired++;
    checks++; if (bus.retired !== TB_CNT_W'(exp_retired)) begin errors++;
      $display("FAIL cbnz_retired: got %0d expected %0d", bus.retired, exp_retired); end
`else
    test_illegal(11'h5A9);
`endif
  endtask

  task automatic test_reset_midop();
    bus.opcode = 11'h7C2; bus.mem_ready = 1'b1; bus.zero = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    bus.mem_ready = 1'b0;
    @(posedge clk); #1;
    checks++; if (bus.state !== 3'd3) begin errors++;
      $display("FAIL midop_pre_state: got %0d expected 3", bus.state); end
    rst = 1'b1; #1;
    exp_retired = 0;
    checks++; if (bus.state !== 3'd0) begin errors++;
      $display("FAIL midop_state: got %0d expected 0", bus.state); end
    checks++; if (bus.retired !== 4'd0) begin errors++;
      $display("FAIL midop_retired: got %0d expected 0", bus.retired); end
    checks++; if (ctl !== C_F0) begin errors++;
      $display("FAIL midop_ctl: got %b expected %b", ctl, C_F0); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_timeout();
    bus.opcode = 11'h458; bus.mem_ready = 1'b0; bus.zero = 1'b0;
    for (int i = 0; i < 16; i++) begin
      #1;
      checks++; if (bus.state !== 3'd0 || ctl !== C_F0) begin errors++;
        $display("FAIL tmo_wait[%0d]: got state %0d ctl %b expected 0 %b", i, bus.state, ctl, C_F0); end
      @(posedge clk); #1;
    end
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (bus.state !== 3'd5) begin errors++;
        $display("FAIL tmo_halt_state[%0d]: got %0d expected 5", i, bus.state); end
      checks++; if (bus.fault !== 1'b1) begin errors++;
        $display("FAIL tmo_fault[%0d]: got %b expected 1", i, bus.fault); end
      checks++; if (ctl !== C_0) begin errors++;
        $display("FAIL tmo_halt_ctl[%0d]: got %b expected %b", i, ctl, C_0); end
      @(posedge clk); #1;
    end
    rst = 1'b1; #1;
    exp_retired = 0;
    checks++; if (bus.state !== 3'd0 || bus.fault !== 1'b0) begin errors++;
      $display("FAIL tmo_reset: got state %0d fault %b expected 0 0", bus.state, bus.fault); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_wrap();
    logic [2:0]  es [3] = '{3'd0, 3'd1, 3'd2};
    logic [12:0] ec [3] = '{C_F1, C_0, C_B};
    bus.opcode = 11'h0A5; bus.mem_ready = 1'b1; bus.zero = 1'b0;
    for (int k = 0; k < 16; k++) begin
      for (int i = 0; i < 3; i++) begin
        #1;
        checks++; if (bus.state !== es[i] || ctl !== ec[i]) begin errors++;
          $display("FAIL b%0d[%0d]: got state %0d ctl %b expected %0d %b",
                   k, i, bus.state, ctl, es[i], ec[i]); end
        @(posedge clk); #1;
      end
      exp_retired++;
      checks++; if (bus.retired !== TB_CNT_W'(exp_retired)) begin errors++;
        $display("FAIL wrap_retired[%0d]: got %0d expected %0d", k, bus.retired,
                 exp_retired % 16); end
    end
  endtask

  initial begin
    checks = 0; errors = 0; exp_retired = 0;
    rst = 1'b1;
    test_reset();
    test_add();
    test_ldur_wait();
    test_stur_wait();
    test_cbz();
    test_illegal(11'h765);
    test_cbnz();
    test_reset_midop();
    test_timeout();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of retired-instruction counter.
REQ-002 SHALL have parameter MEM_TIMEOUT, default 15, max mem_ready wait cycles before fault.
REQ-003 SHALL have clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have opcode  input  11  instruction bits [31:21], sampled in DECODE.
REQ-006 SHALL have mem_ready  input  1  memory handshake, access completes on the cycle it is high.
REQ-007 SHALL have zero  input  1  ALU zero flag, sampled in EXECUTE.
REQ-008 SHALL have reg2_loc, uncondbranch, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write  output  1 each  datapath controls.
REQ-009 SHALL have alu_op  output  2  00 add, 01 pass-B/zero-test, 10 R-type funct.
REQ-010 SHALL have pc_write, ir_write  output  1 each  PC and instruction-register enables.
REQ-011 SHALL have illegal  output  1  one-cycle pulse on an undecodable opcode.
REQ-012 SHALL have fault  output  1  sticky memory-timeout flag.
REQ-013 SHALL have state  output  3  current FSM state encoding.
REQ-014 SHALL have retired  output  CNT_W  count of completed instructions.

Function
REQ-015 SHALL implement states FETCH(0), DECODE(1), EXECUTE(2), MEMORY(3), WRITEBACK(4), HALT(5).
REQ-016 FETCH: mem_read=1, ir_write=mem_ready; stays while mem_ready=0; goes to DECODE when mem_ready=1.
REQ-017 DECODE: classify opcode: ADD 458, SUB 658, AND 450, ORR 550, LDUR 7C2, STUR 7C0, CBZ 5A0-5A7, B 0A0-0BF. Valid goes to EXECUTE; invalid pulses illegal, returns to FETCH, does not advance retired.
REQ-018 DECODE: reg2_loc=1 for STUR and CBZ, else 0.
REQ-019 EXECUTE R-type: alu_op=10, alu_src=0, then go to WRITEBACK.
REQ-020 EXECUTE LDUR/STUR: alu_op=00, alu_src=1, then go to MEMORY.
REQ-021 EXECUTE CBZ: alu_op=01, branch=1, pc_write=zero; B: uncondbranch=1, pc_write=1. Both go to FETCH and retire.
REQ-022 MEMORY: LDUR drives mem_read=1 and STUR drives mem_write=1 until mem_ready. On mem_ready, LDUR goes to WRITEBACK; STUR goes to FETCH and retires.
REQ-023 WRITEBACK: reg_write=1 and pc_write=1, plus mem_to_reg=1 for LDUR; goes to FETCH and retires.
REQ-024 Non-branch instructions SHALL assert pc_write (PC+4) exactly once, in their final cycle.
REQ-025 Latency, with zero wait states: R-type 4, LDUR 5, STUR 4, CBZ/B 3 cycles.
REQ-026 Each mem_ready wait cycle in FETCH or MEMORY SHALL add one cycle.
REQ-027 A wait exceeding MEM_TIMEOUT cycles SHALL set fault and enter HALT.
REQ-028 HALT: all controls 0; state is left only by reset.
REQ-029 retired SHALL wrap from 2^CNT_W-1 to 0 without a flag.
REQ-030 All outputs not named for a state SHALL be 0 in that state.
REQ-031 Controls SHALL decode combinationally from registered state plus the latched instruction class.

Reset
REQ-032 rst SHALL force FETCH, fault=0, retired=0 and the instruction class to NOP immediately, including mid-instruction or mid-memory-wait.
REQ-033 In reset, all outputs SHALL be 0 except state=0 and mem_read=1.

Configuration
REQ-034 With CBNZ_EN defined, opcodes 5A8-5AF SHALL decode as CBNZ: same as CBZ but pc_write=!zero.
REQ-035 Without CBNZ_EN, opcodes 5A8-5AF SHALL be illegal.

Structure
REQ-036 Package multicycle_pkg SHALL hold the state enum, instruction-class enum, opcode constants/masks and alu_op constants.
REQ-037 Sub-module opcode_decoder SHALL be combinational opcode to class mapping, with a valid bit.

Verification
REQ-038 ADD 458, mem_ready=1 always -> states 0,1,2,4,0; reg_write and pc_write in cycle 4; retired=1.
REQ-039 LDUR 7C2, mem_ready low 3 cycles in MEMORY -> 8 cycles total; mem_to_reg=1 and reg_write=1 in WRITEBACK.
REQ-040 CBZ 5A3 with zero=1 -> pc_write=1 and branch=1 in EXECUTE; with zero=0 -> pc_write=0; both retire in 3 cycles.
REQ-041 Opcode 765 -> illegal pulse of 1 cycle, back in FETCH, retired unchanged.
REQ-042 mem_ready=0 held for 16 cycles in FETCH -> fault=1, state=5 held; rst -> state=0, fault=0.
REQ-043 Opcode 5A9: with CBNZ_EN and zero=0 -> pc_write=1; without CBNZ_EN -> illegal=1.
